regfile_dump_reader: RTL and testbench

- Read-side companion to the 32x32 register file.
- On a start pulse, walks an inclusive register index range.
- For each index: drives the register file's read address, captures the read data, and emits one {index, data} beat on a valid/ready stream.
- Used by the debug/trace path to dump CPU architectural state without stalling writeback.

---
 rtl/regfile_dump_reader_pkg.sv | 15 +
 rtl/regfile_dump_reader.sv | 133 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared register-file geometry and dump-reader state encoding.
package regfile_dump_reader_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        FIN   = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register index range and streams {index, data} beats,
// forwarding a same-cycle writeback so each beat reflects post-write state.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] busA,
    input  logic              regwr,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] busW,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Read value as seen after this edge's writeback; index 0 is hardwired zero.
    function automatic logic [DATA_W-1:0] bypass_sel(
        input logic [ADDR_W-1:0] rd_idx,
        input logic [DATA_W-1:0] rd_data,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_idx,
        input logic [DATA_W-1:0] wr_data
    );
        if (rd_idx == '0) begin
            return '0;
        end
        if (wr_en && (wr_idx == rd_idx)) begin
            return wr_data;
        end
        return rd_data;
    endfunction

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        end_d   = end_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (first <= last) begin
                        cur_d   = first;
                        end_d   = last;
                        state_d = FETCH;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FETCH: begin
                data_d  = bypass_sel(cur_q, busA, regwr, rw, busW);
                idx_d   = cur_q;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (cur_q == end_q) begin
                        state_d = FIN;
                    end else begin
                        cur_d   = cur_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered views of the state being entered.
        busy_d = (state_d == FETCH) || (state_d == SEND);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            end_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // cur only moves at start/handshake edges, so it already holds between fetches.
    assign ra        = cur_q;
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: register-file model, beat scoreboard,
// directed scenarios and randomized dumps with random writeback and backpressure.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    localparam int unsigned AW = REG_ADDR_W;
    localparam int unsigned DW = REG_DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic [AW-1:0] ra;
    logic [DW-1:0] busA;
    logic          regwr;
    logic [AW-1:0] rw;
    logic [DW-1:0] busW;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .first(first), .last(last),
        .ra(ra), .busA(busA), .regwr(regwr), .rw(rw), .busW(busW),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .busy(busy), .done(done)
    );

    // Register file model: reg0 always reads zero.
    logic [DW-1:0] mem [NUM_REGS];
    assign busA = mem[ra];
    always @(posedge clk) begin
        if (regwr) mem[rw] <= (rw == '0) ? '0 : busW;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] i);
        return (i == '0) ? '0 : mem[i];
    endfunction

    // Scoreboard: indices still owed by the current dump, in order.
    logic [AW-1:0] exp_q[$];
    logic          holding = 1'b0;
    logic [AW-1:0] h_idx;
    logic [DW-1:0] h_data;
    int            beats = 0;
    int            dones = 0;

    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
        end else begin
            if (out_valid) begin
                if (!holding) begin
                    check_val("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        check_val("beat_idx", 32'(out_idx), 32'(exp_q[0]));
                        check_val("beat_data", out_data, ref_val(exp_q[0]));
                    end
                    h_idx   = out_idx;
                    h_data  = out_data;
                    holding = 1'b1;
                    beats++;
                end else begin
                    check_val("hold_idx", 32'(out_idx), 32'(h_idx));
                    check_val("hold_data", out_data, h_data);
                end
                if (out_ready) begin
                    holding = 1'b0;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
            if (done) dones++;
        end
    end

    logic          rand_ready = 1'b0;
    logic          rand_wr    = 1'b0;
    logic [AW-1:0] stall_idx  = '0;
    int            stall_left = 0;

    // Advance one cycle, then drive this cycle's inputs.
    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        if (rand_ready) begin
            out_ready = 1'($urandom_range(0, 1));
        end else if (stall_left > 0 && out_valid && out_idx == stall_idx) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
        if (rand_wr) begin
            regwr = ($urandom_range(0, 2) == 0);
            rw    = AW'($urandom_range(0, 31));
            busW  = $urandom;
        end else begin
            regwr = 1'b0;
        end
    endtask

    task automatic wr(input logic [AW-1:0] i, input logic [DW-1:0] v);
        regwr = 1'b1;
        rw    = i;
        busW  = v;
        step();
    endtask

    task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        first = f;
        last  = l;
        start = 1'b1;
        if (f <= l) begin
            for (int i = int'(f); i <= int'(l); i++) exp_q.push_back(AW'(i));
        end
        step();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check_val("done_seen", 32'(done), 32'd1);
        step();
    endtask

    task automatic reach_idx2();
        int n = 0;
        while (!(out_valid && out_idx == AW'(2)) && n < 20) begin
            step();
            n++;
        end
        check_val("reach_idx2", 32'(out_valid && out_idx == AW'(2)), 32'd1);
    endtask

    initial begin
        logic [7:0] pat_v, pat_b, pat_d;
        int b0, d0, nexp;
        logic [AW-1:0] f, l;

        rst = 1'b1; start = 1'b0; first = '0; last = '0;
        regwr = 1'b0; rw = '0; busW = '0; out_ready = 1'b1;
        step();
        step();
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_idx", 32'(out_idx), 32'd0);
        check_val("rst_data", out_data, 32'd0);
        check_val("rst_ra", 32'(ra), 32'd0);
        rst = 1'b0;
        step();

        // Preload the register file.
        wr(AW'(0), 32'd0);
        for (int i = 1; i < 32; i++) begin
            case (i)
                1: wr(AW'(i), 32'h11);
                2: wr(AW'(i), 32'h22);
                3: wr(AW'(i), 32'h33);
                5: wr(AW'(i), 32'h1);
                default: wr(AW'(i), $urandom);
            endcase
        end

        // Basic dump 1..3: cycle-by-cycle valid/busy/done profile.
        pat_v = 8'b0010_1010;
        pat_b = 8'b0011_1111;
        pat_d = 8'b0100_0000;
        d0 = dones;
        do_start(AW'(1), AW'(3));
        for (int k = 0; k < 8; k++) begin
            check_val("t1_valid", 32'(out_valid), 32'(pat_v[k]));
            check_val("t1_busy", 32'(busy), 32'(pat_b[k]));
            check_val("t1_done", 32'(done), 32'(pat_d[k]));
            if (k == 1) begin
                check_val("t1_idx1", 32'(out_idx), 32'd1);
                check_val("t1_data1", out_data, 32'h11);
            end
            step();
        end
        check_val("t1_done_count", 32'(dones - d0), 32'd1);

        // Backpressure on idx 2 while reg2 is overwritten.
        stall_idx = AW'(2);
        stall_left = 5;
        do_start(AW'(1), AW'(3));
        reach_idx2();
        check_val("t3_data_old", out_data, 32'h22);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                regwr = 1'b1; rw = AW'(2); busW = 32'hBEEF;
            end
            step();
            check_val("t3_valid", 32'(out_valid), 32'd1);
            check_val("t3_idx", 32'(out_idx), 32'd2);
            check_val("t3_data", out_data, 32'h22);
        end
        wait_done(40);
        check_val("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Writeback to reg5 in the very cycle it is fetched.
        do_start(AW'(4), AW'(6));
        step();
        step();
        check_val("t4_ra", 32'(ra), 32'd5);
        regwr = 1'b1; rw = AW'(5); busW = 32'hCAFE;
        step();
        check_val("t4_idx", 32'(out_idx), 32'd5);
        check_val("t4_data", out_data, 32'hCAFE);
        wait_done(40);

        // Empty range.
        b0 = beats;
        do_start(AW'(7), AW'(4));
        check_val("t5_done", 32'(done), 32'd1);
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_valid", 32'(out_valid), 32'd0);
        step();
        check_val("t5_done_low", 32'(done), 32'd0);
        check_val("t5_busy_low", 32'(busy), 32'd0);
        check_val("t5_no_beats", 32'(beats - b0), 32'd0);

        // Full range, with a write to reg0 that must stay invisible.
        wr(AW'(0), 32'hDEAD);
        b0 = beats;
        do_start(AW'(0), AW'(31));
        wait_done(200);
        check_val("t2_beats", 32'(beats - b0), 32'd32);
        check_val("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while the second beat is held.
        stall_idx = AW'(2);
        stall_left = 10;
        d0 = dones;
        do_start(AW'(1), AW'(3));
        reach_idx2();
        rst = 1'b1;
        step();
        rst = 1'b0;
        stall_left = 0;
        exp_q.delete();
        check_val("t6_valid", 32'(out_valid), 32'd0);
        check_val("t6_busy", 32'(busy), 32'd0);
        check_val("t6_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check_val("t6_no_done", 32'(dones - d0), 32'd0);
        b0 = beats;
        do_start(AW'(1), AW'(1));
        wait_done(40);
        check_val("t6_one_beat", 32'(beats - b0), 32'd1);

        // Second start mid-dump is ignored.
        b0 = beats;
        d0 = dones;
        do_start(AW'(2), AW'(5));
        step();
        step();
        first = AW'(9); last = AW'(12); start = 1'b1;
        step();
        wait_done(100);
        check_val("t7_beats", 32'(beats - b0), 32'd4);
        check_val("t7_dones", 32'(dones - d0), 32'd1);

        // Randomized ranges with random backpressure and writeback traffic.
        rand_ready = 1'b1;
        rand_wr    = 1'b1;
        for (int it = 0; it < 12; it++) begin
            f = AW'($urandom_range(0, 31));
            l = AW'($urandom_range(0, 31));
            if (it == 0) begin
                f = AW'(0); l = AW'(31);
            end
            nexp = (f <= l) ? (int'(l) - int'(f) + 1) : 0;
            b0 = beats;
            do_start(f, l);
            wait_done(400);
            check_val("rnd_beats", 32'(beats - b0), 32'(nexp));
            check_val("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        end
        rand_ready = 1'b0;
        rand_wr    = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
